// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store unit: data_memory geometry, access-size
// masks, RV32I load/store funct3 codes and the LSU state type.
package lsu_mem_ctrl_pkg;

  localparam int MEM_ADDR_WIDTH = 10;
  localparam int REG_DATA_WIDTH = 32;
  localparam int MASK_WIDTH     = 2;

  localparam logic [MASK_WIDTH-1:0] MASK_B = 2'b00;
  localparam logic [MASK_WIDTH-1:0] MASK_H = 2'b01;
  localparam logic [MASK_WIDTH-1:0] MASK_W = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_LB, F3_LH, F3_LW: ok = 1'b1;
      F3_LBU, F3_LHU:      ok = ~we;
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Only H and W can be misaligned; the illegal size code 2'b11 never is.
  function automatic logic access_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (f3[1:0])
      2'b01:   mis = addr_lo[0];
      2'b10:   mis = |addr_lo;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [MASK_WIDTH-1:0] size_mask(input logic [2:0] f3);
    logic [MASK_WIDTH-1:0] m;
    case (f3[1:0])
      2'b00:   m = MASK_B;
      2'b01:   m = MASK_H;
      default: m = MASK_W;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_load_ext.sv
// Sign/zero extension of raw little-endian load data according to funct3.
module lsu_load_ext
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = REG_DATA_WIDTH
) (
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] raw,
  output logic [DATA_WIDTH-1:0] data
);

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    data = raw;
    case (funct3)
      F3_LB:   data = {{(DATA_WIDTH-8){raw[7]}}, raw[7:0]};
      F3_LH:   data = {{(DATA_WIDTH-16){raw[15]}}, raw[15:0]};
      F3_LBU:  data = {{(DATA_WIDTH-8){1'b0}}, raw[7:0]};
      F3_LHU:  data = {{(DATA_WIDTH-16){1'b0}}, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Single-outstanding load/store initiator for data_memory with a valid/ready
// response channel. Define LSU_MISALIGNED_SPLIT_EN to split misaligned H/W
// accesses into byte accesses instead of faulting them.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = REG_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [2:0]                req_funct3,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [DATA_WIDTH-1:0]     resp_rdata,
  output logic                      resp_fault,
  output logic                      mem_rd_en,
  output logic                      mem_wr_en,
  output logic [MASK_WIDTH-1:0]     mem_mask,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wr_data,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data
);

  lsu_state_t state, state_next;

  logic                      we_q;
  logic [2:0]                funct3_q;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [DATA_WIDTH-1:0]     raw_q;
  logic                      fault_q;
  logic [DATA_WIDTH-1:0]     load_data;

  logic req_fire;
  logic req_legal;
  logic req_misaligned;
  logic req_fault;
  logic unused_addr_hi;

  assign req_fire       = req_valid & req_ready;
  assign req_legal      = funct3_legal(req_we, req_funct3);
  assign req_misaligned = access_misaligned(req_funct3, req_addr[1:0]);
  // Addresses beyond data_memory simply wrap; the upper bits carry no meaning.
  assign unused_addr_hi = ^req_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH];

`ifdef LSU_MISALIGNED_SPLIT_EN
  logic       split_q;
  logic       req_split;
  logic [1:0] byte_cnt;
  logic [1:0] last_cnt;

  assign req_fault = ~req_legal;
  assign req_split = req_legal & req_misaligned;
  assign last_cnt  = (funct3_q[1:0] == 2'b01) ? 2'd1 : 2'd3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      split_q  <= 1'b0;
      byte_cnt <= 2'd0;
    end else if (req_fire) begin
      split_q  <= req_split;
      byte_cnt <= 2'd0;
    end else if (state == ACCESS) begin
      byte_cnt <= byte_cnt + 2'd1;
    end
  end
`else
  assign req_fault = ~req_legal | req_misaligned;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_fire) state_next = req_fault ? RESP : ACCESS;
`ifdef LSU_MISALIGNED_SPLIT_EN
      ACCESS:  state_next = (split_q && byte_cnt != last_cnt) ? ACCESS : RESP;
`else
      ACCESS:  state_next = RESP;
`endif
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture; the raw buffer is cleared on accept so split loads
  // assemble into zeroed upper bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      fault_q  <= 1'b0;
      raw_q    <= '0;
    end else if (req_fire) begin
      we_q     <= req_we;
      funct3_q <= req_funct3;
      addr_q   <= req_addr[MEM_ADDR_WIDTH-1:0];
      wdata_q  <= req_wdata;
      fault_q  <= req_fault;
      raw_q    <= '0;
    end else if (state == ACCESS && !we_q) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
      if (split_q) raw_q[{byte_cnt, 3'b000} +: 8] <= mem_rd_data[7:0];
      else         raw_q <= mem_rd_data;
`else
      raw_q <= mem_rd_data;
`endif
    end
  end

  lsu_load_ext #(.DATA_WIDTH(DATA_WIDTH)) u_load_ext (
    .funct3 (funct3_q),
    .raw    (raw_q),
    .data   (load_data)
  );

  always_comb begin
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_rdata  = '0;
    resp_fault  = 1'b0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_mask    = '0;
    mem_addr    = '0;
    mem_wr_data = '0;
    case (state)
      IDLE: req_ready = 1'b1;
      ACCESS: begin
        mem_rd_en   = ~we_q;
        mem_wr_en   = we_q;
        mem_mask    = size_mask(funct3_q);
        mem_addr    = addr_q;
        mem_wr_data = wdata_q;
`ifdef LSU_MISALIGNED_SPLIT_EN
        if (split_q) begin
          mem_mask    = MASK_B;
          mem_addr    = addr_q + MEM_ADDR_WIDTH'(byte_cnt);
          mem_wr_data = {{(DATA_WIDTH-8){1'b0}}, wdata_q[{byte_cnt, 3'b000} +: 8]};
        end
`endif
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_fault = fault_q;
        resp_rdata = (fault_q || we_q) ? '0 : load_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: byte-array data_memory, reference model of
// the load/store rules, random plus directed traffic, stall and reset cases.
module tb_lsu_mem_ctrl;
  import lsu_mem_ctrl_pkg::*;

  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int MEM_BYTES = 1 << MEM_ADDR_WIDTH;
`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      req_valid = 1'b0;
  logic                      req_ready;
  logic                      req_we = 1'b0;
  logic [2:0]                req_funct3 = '0;
  logic [AW-1:0]             req_addr = '0;
  logic [DW-1:0]             req_wdata = '0;
  logic                      resp_valid;
  logic                      resp_ready = 1'b0;
  logic [DW-1:0]             resp_rdata;
  logic                      resp_fault;
  logic                      mem_rd_en;
  logic                      mem_wr_en;
  logic [MASK_WIDTH-1:0]     mem_mask;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [DW-1:0]             mem_wr_data;
  logic [DW-1:0]             mem_rd_data;

  lsu_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk), .rst (rst),
    .req_valid (req_valid), .req_ready (req_ready), .req_we (req_we),
    .req_funct3 (req_funct3), .req_addr (req_addr), .req_wdata (req_wdata),
    .resp_valid (resp_valid), .resp_ready (resp_ready),
    .resp_rdata (resp_rdata), .resp_fault (resp_fault),
    .mem_rd_en (mem_rd_en), .mem_wr_en (mem_wr_en), .mem_mask (mem_mask),
    .mem_addr (mem_addr), .mem_wr_data (mem_wr_data), .mem_rd_data (mem_rd_data)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
    int          n_acc;
    int          acc_cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem     [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];
  int         n_checks = 0;
  int         n_pass = 0;
  int         cyc = 0;
  bit         hold_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int mask_bytes(input logic [MASK_WIDTH-1:0] m);
    if (m == MASK_B) return 1;
    if (m == MASK_H) return 2;
    return 4;
  endfunction

  // data_memory stand-in: zero-extended combinational read, writes committed
  // mid-cycle while wr_en is asserted.
  always_comb begin
    mem_rd_data = '0;
    for (int i = 0; i < 4; i++)
      if (i < mask_bytes(mem_mask)) mem_rd_data[8*i +: 8] = mem[(int'(mem_addr) + i) % MEM_BYTES];
  end

  initial forever begin
    @(negedge clk);
    if (!rst && mem_wr_en)
      for (int i = 0; i < mask_bytes(mem_mask); i++)
        mem[(int'(mem_addr) + i) % MEM_BYTES] = mem_wr_data[8*i +: 8];
  end

  initial forever begin
    @(posedge clk);
    cyc++;
    #1 resp_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Reference model: architectural effect of one request on ref_mem.
  task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output exp_t e);
    int          n;
    bit          illegal;
    bit          mis;
    logic [31:0] v;
    v = '0;
    n = 1 << f3[1:0];
    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]);
    mis = !illegal && ((addr % n) != 0);
    e = '{rdata: 32'h0, fault: 1'b0, lat: 2, n_acc: 1, acc_cyc: 0};
    if (illegal || (mis && !SPLIT)) begin
      e.fault = 1'b1;
      e.lat   = 1;
      e.n_acc = 0;
      return;
    end
    if (mis) begin
      e.lat   = n + 1;
      e.n_acc = n;
    end
    for (int i = 0; i < n; i++) begin
      int a;
      a = int'((addr + i) % MEM_BYTES);
      if (we) ref_mem[a] = wd[8*i +: 8];
      else    v[8*i +: 8] = ref_mem[a];
    end
    if (!we) begin
      if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      e.rdata = v;
    end
  endtask

  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input bit track = 1'b1,
                        input bit use_lit = 1'b0, input logic [31:0] lit = 32'h0);
    exp_t e;
    int   waited;
    waited = 0;
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    while (!req_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check("req_accept_timeout", 32'(req_ready), 32'h1);
      req_valid = 1'b0;
      return;
    end
    if (track) begin
      model(we, f3, addr, wd, e);
      if (use_lit) e.rdata = lit;
      e.acc_cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
  endtask

  // Monitor: compares every response handshake against the scoreboard head.
  initial begin
    int          acc_cnt;
    int          first_cyc;
    bit          seen;
    bit          have_prev;
    logic [31:0] prev_rdata;
    logic        prev_fault;
    exp_t        e;
    acc_cnt = 0; first_cyc = 0; seen = 0; have_prev = 0;
    prev_rdata = '0; prev_fault = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        acc_cnt = 0; seen = 0; have_prev = 0;
      end else begin
        if (have_prev) begin
          check("stall_valid_held", 32'(resp_valid), 32'h1);
          check("stall_rdata_held", resp_rdata, prev_rdata);
          check("stall_fault_held", 32'(resp_fault), 32'(prev_fault));
          have_prev = 0;
        end
        if (mem_rd_en || mem_wr_en) acc_cnt++;
        if (resp_valid && !seen) begin
          seen = 1;
          first_cyc = cyc;
        end
        if (resp_valid) begin
          if (resp_ready) begin
            if (sb.size() == 0) begin
              check("unexpected_resp", 32'h1, 32'h0);
            end else begin
              e = sb.pop_front();
              check("resp_rdata", resp_rdata, e.rdata);
              check("resp_fault", 32'(resp_fault), 32'(e.fault));
              check("resp_latency", first_cyc - e.acc_cyc, e.lat);
              check("mem_access_cycles", acc_cnt, e.n_acc);
            end
            acc_cnt = 0; seen = 0;
          end else begin
            have_prev = 1;
            prev_rdata = resp_rdata;
            prev_fault = resp_fault;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          k;
    int          bad;

    for (int i = 0; i < MEM_BYTES; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    {mem[16'h13], mem[16'h12], mem[16'h11], mem[16'h10]} = 32'h8765_4321;
    {mem[16'h17], mem[16'h16], mem[16'h15], mem[16'h14]} = 32'hAABB_CCDD;
    for (int i = 16'h10; i < 16'h18; i++) ref_mem[i] = mem[i];

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_fault", 32'(resp_fault), 32'h0);
    check("rst_mem_rd_en", 32'(mem_rd_en), 32'h0);
    check("rst_mem_wr_en", 32'(mem_wr_en), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    rst = 1'b0;

    do_req(1'b0, F3_LB,  32'h13, 32'h0, 1'b1, 1'b1, 32'hFFFF_FF87);
    do_req(1'b0, F3_LHU, 32'h12, 32'h0, 1'b1, 1'b1, 32'h0000_8765);
    do_req(1'b0, F3_LH,  32'h10, 32'h0, 1'b1, 1'b1, 32'h0000_4321);
    do_req(1'b0, F3_LW,  32'h10, 32'h0, 1'b1, 1'b1, 32'h8765_4321);
    do_req(1'b0, F3_LW,  32'h11, 32'h0, 1'b1, 1'b1, SPLIT ? 32'hDD87_6543 : 32'h0);
    do_req(1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 1'b1, 32'h0);
    do_req(1'b1, 3'b100, 32'h18, 32'h55, 1'b1, 1'b1, 32'h0);
    do_req(1'b1, F3_SB,  32'h12, 32'h0000_00FF, 1'b1, 1'b1, 32'h0);
    do_req(1'b0, F3_LW,  32'h10, 32'h0, 1'b1, 1'b1, 32'h87FF_4321);
    do_req(1'b1, F3_SH,  32'h10, 32'h0000_BEEF, 1'b1, 1'b1, 32'h0);
    do_req(1'b0, F3_LW,  32'h10, 32'h0, 1'b1, 1'b1, 32'h87FF_BEEF);
    do_req(1'b1, F3_SH,  32'h13, 32'h0000_1234, 1'b1, 1'b1, 32'h0);
    do_req(1'b0, F3_LBU, 32'h13, 32'h0);
    do_req(1'b0, F3_LBU, 32'h14, 32'h0);
    do_req(1'b0, F3_LW,  32'h3FF, 32'h0);
    do_req(1'b1, F3_SW,  32'h3FE, 32'hCAFE_F00D);
    do_req(1'b0, F3_LW,  32'h3FE, 32'h0);
    do_req(1'b0, F3_LH,  32'h0, 32'h0);
    do_req(1'b0, F3_LB,  32'h7FF, 32'h0);
    do_req(1'b0, F3_LW,  32'hFFFF_FC10, 32'h0);

    repeat (300) begin
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = 32'($urandom_range(0, 2047));
      if ($urandom_range(0, 3) == 0) addr = addr | 32'hFFFF_F000;
      do_req(we, f3, addr, $urandom);
    end
    wait_idle();

    // Stalled response must hold its payload and keep req_ready low.
    hold_ready = 1'b1;
    do_req(1'b0, F3_LW, 32'h14, 32'h0);
    k = 0;
    while (!resp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    repeat (3) begin
      check("hold_resp_valid", 32'(resp_valid), 32'h1);
      check("hold_req_ready", 32'(req_ready), 32'h0);
      @(negedge clk);
    end
    hold_ready = 1'b0;
    wait_idle();

    // Reset in the middle of a store: aborts at once, no further bytes land.
`ifdef LSU_MISALIGNED_SPLIT_EN
    do_req(1'b1, F3_SW, 32'h21, 32'hA1B2_C3D4, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    ref_mem[16'h21] = 8'hD4;
`else
    do_req(1'b1, F3_SW, 32'h20, 32'hA1B2_C3D4, 1'b0);
    #1 rst = 1'b1;
`endif
    #1;
    check("abort_req_ready", 32'(req_ready), 32'h1);
    check("abort_resp_valid", 32'(resp_valid), 32'h0);
    check("abort_mem_wr_en", 32'(mem_wr_en), 32'h0);
    check("abort_mem_rd_en", 32'(mem_rd_en), 32'h0);
    check("abort_mem_addr", 32'(mem_addr), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 16'h20; i < 16'h25; i++) check("abort_mem_byte", 32'(mem[i]), 32'(ref_mem[i]));

    repeat (20) begin
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom_range(16'h1E, 16'h28)), $urandom);
    end
    wait_idle();

    bad = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("mem_image_diff_bytes", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
